// File: rtl/rj_sample_buf.sv
// Multi-channel sample store for right-justified audio words, with sweep clear,
// per-slot valid bits and frame pulse. Optional macro RJ_SIGN_EXT_EN sign-extends input.
module rj_sample_buf #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned IN_W     = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned ROW_W   = $clog2(DEPTH),
  localparam int unsigned CH_W    = $clog2(CHANNELS)
) (
  input  logic              Sclk,
  input  logic              clear,
  input  logic              init,
  input  logic              rj_status,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ROW_W:0]    wr_row,
  input  logic [IN_W-1:0]   Input,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ROW_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              wr_drop
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  ptr_q, ptr_d;
  logic              rj_q;
  logic              wr_fire;
  logic              wr_ok;
  logic              wr_accept;
  logic              rd_zero;
  logic [ROW_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_word;

  logic [DATA_W-1:0] mem [CHANNELS][DEPTH];
  logic [DEPTH-1:0]  valid_q [CHANNELS];

  assign wr_idx  = wr_row[ROW_W-1:0];
  assign wr_fire = rj_status & ~rj_q;
  assign busy    = (state_q == StSweep);

  // init in the same cycle as a strobe wins; the write is rejected.
  assign wr_ok     = (state_q == StIdle) & ~init & ~wr_row[ROW_W] & (32'(wr_ch) < CHANNELS);
  assign wr_accept = wr_fire & wr_ok;

  // Zero reads both during and on entry to a sweep so no stale word leaks out.
  assign rd_zero = (state_q == StSweep) | (state_d == StSweep) | (32'(rd_ch) >= CHANNELS);

  always_comb begin
`ifdef RJ_SIGN_EXT_EN
    wr_word = {DATA_W{Input[IN_W-1]}};
`else
    wr_word = '0;
`endif
    wr_word[IN_W-1:0] = Input;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (init) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        if (init) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + ROW_W'(1);
          if (ptr_q == ROW_W'(DEPTH - 1)) state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge Sclk or posedge clear) begin
    if (clear) begin
      state_q    <= StSweep;
      ptr_q      <= '0;
      rj_q       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      frame_done <= 1'b0;
      wr_drop    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) valid_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rj_q       <= rj_status;
      frame_done <= wr_accept & (32'(wr_ch) == CHANNELS - 1) & (32'(wr_idx) == DEPTH - 1);
      if (wr_fire && !wr_ok) begin
        wr_drop <= 1'b1;
      end else if (state_q == StIdle && init) begin
        wr_drop <= 1'b0;
      end
      if (rd_zero) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_data  <= mem[rd_ch][rd_idx];
        rd_valid <= valid_q[rd_ch][rd_idx];
      end
      if (state_q == StSweep) begin
        for (int c = 0; c < CHANNELS; c++) valid_q[CH_W'(c)][ptr_q] <= 1'b0;
      end else if (wr_accept) begin
        valid_q[wr_ch][wr_idx] <= 1'b1;
      end
    end
  end

  // Storage array is deliberately not reset; the post-reset sweep zeroes it.
  always_ff @(posedge Sclk) begin
    if (state_q == StSweep) begin
      for (int c = 0; c < CHANNELS; c++) mem[CH_W'(c)][ptr_q] <= '0;
    end else if (wr_accept) begin
      mem[wr_ch][wr_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_rj_sample_buf.sv
// Bench for rj_sample_buf: cycle model compared every cycle plus directed literal checks.
// A second instance with IN_W=12 covers input extension (RJ_SIGN_EXT_EN aware).
module tb_rj_sample_buf;

  localparam int DEP = 16;
  localparam int CH  = 2;

`ifdef RJ_SIGN_EXT_EN
  localparam logic [15:0] ExpExt = 16'hF800;
`else
  localparam logic [15:0] ExpExt = 16'h0800;
`endif

  logic        Sclk = 1'b0;
  logic        clear = 1'b0;
  logic        init = 1'b0;
  logic        rj_status = 1'b0;
  logic [0:0]  wr_ch = '0;
  logic [4:0]  wr_row = '0;
  logic [15:0] Input = '0;
  logic [0:0]  rd_ch = '0;
  logic [3:0]  rd_idx = '0;
  logic [15:0] rd_data;
  logic        rd_valid, busy, frame_done, wr_drop;

  logic        init_e = 1'b0;
  logic        rj_e = 1'b0;
  logic [0:0]  wr_ch_e = '0;
  logic [4:0]  wr_row_e = '0;
  logic [11:0] in_e = '0;
  logic [0:0]  rd_ch_e = '0;
  logic [3:0]  rd_idx_e = '0;
  logic [15:0] rd_data_e;
  logic        rd_valid_e, busy_e, frame_done_e, wr_drop_e;

  rj_sample_buf #(.DATA_W(16), .IN_W(16), .DEPTH(DEP), .CHANNELS(CH)) u_dut (
    .Sclk(Sclk), .clear(clear), .init(init), .rj_status(rj_status), .wr_ch(wr_ch),
    .wr_row(wr_row), .Input(Input), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .frame_done(frame_done), .wr_drop(wr_drop)
  );

  rj_sample_buf #(.DATA_W(16), .IN_W(12), .DEPTH(DEP), .CHANNELS(CH)) u_ext (
    .Sclk(Sclk), .clear(clear), .init(init_e), .rj_status(rj_e), .wr_ch(wr_ch_e),
    .wr_row(wr_row_e), .Input(in_e), .rd_ch(rd_ch_e), .rd_idx(rd_idx_e), .rd_data(rd_data_e),
    .rd_valid(rd_valid_e), .busy(busy_e), .frame_done(frame_done_e), .wr_drop(wr_drop_e)
  );

  always #5 Sclk = ~Sclk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  // Behavioural model: remaining sweep cycles, storage contents and sticky flags.
  logic [15:0] m_mem [CH][DEP];
  bit          m_vld [CH][DEP];
  int          m_sweep_left;
  bit          m_drop, m_frame, m_rj, m_rdv;
  logic [15:0] m_rd;

  always @(posedge Sclk or posedge clear) begin
    if (clear) begin
      m_sweep_left = DEP;
      m_drop = 0; m_frame = 0; m_rj = 0; m_rd = '0; m_rdv = 0;
    end else begin
      bit sweeping, fire, acc, sweep_next;
      int row;
      sweeping   = m_sweep_left > 0;
      fire       = rj_status && !m_rj;
      sweep_next = init || m_sweep_left > 1;
      if (sweeping || sweep_next) begin
        m_rd = '0; m_rdv = 0;
      end else begin
        m_rd = m_mem[rd_ch][rd_idx]; m_rdv = m_vld[rd_ch][rd_idx];
      end
      acc = fire && !sweeping && !init && wr_row < DEP && wr_ch < CH;
      if (sweeping) begin
        row = DEP - m_sweep_left;
        for (int c = 0; c < CH; c++) begin
          m_mem[c][row] = '0; m_vld[c][row] = 0;
        end
      end
      if (acc) begin
        m_mem[wr_ch][wr_row[3:0]] = Input; m_vld[wr_ch][wr_row[3:0]] = 1;
      end
      if (fire && !acc) m_drop = 1;
      else if (!sweeping && init) m_drop = 0;
      m_frame = acc && wr_ch == CH - 1 && wr_row == DEP - 1;
      m_sweep_left = init ? DEP : (sweeping ? m_sweep_left - 1 : 0);
      m_rj = rj_status;
    end
  end

  always @(negedge Sclk) begin
    if (chk_en) begin
      chk("cyc_rd_data", rd_data, m_rd);
      chk("cyc_rd_valid", rd_valid, m_rdv);
      chk("cyc_busy", busy, m_sweep_left > 0);
      chk("cyc_frame_done", frame_done, m_frame);
      chk("cyc_wr_drop", wr_drop, m_drop);
    end
  end

  task automatic strobe(input logic [0:0] ch, input logic [4:0] row, input logic [15:0] d,
                        input int hold);
    @(negedge Sclk);
    wr_ch = ch; wr_row = row; Input = d; rj_status = 1'b1;
    repeat (hold) begin
      @(negedge Sclk);
      Input = ~d;
    end
    rj_status = 1'b0;
  endtask

  task automatic rd(input logic [0:0] ch, input logic [3:0] idx, input logic [15:0] exp_d,
                    input logic exp_v, input string nm);
    @(negedge Sclk);
    rd_ch = ch; rd_idx = idx;
    @(negedge Sclk);
    chk({nm, "_data"}, rd_data, exp_d);
    chk({nm, "_valid"}, rd_valid, exp_v);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge Sclk);
      n++;
    end
    chk(nm, n, 16);
  endtask

  initial begin
    repeat (2) @(negedge Sclk);
    clear = 1'b1;
    @(negedge Sclk);
    chk_en = 1;
    chk("rst_busy", busy, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_drop", wr_drop, 0);
    @(negedge Sclk);
    clear = 1'b0;
    count_busy("t1_busy_cycles");
    rd(0, 7, 16'h0000, 0, "t1_rd07");
    rd(1, 15, 16'h0000, 0, "t1_rd115");

    // Data changes while the strobe is held, so a retrigger would store ~0xA5C3.
    strobe(1, 5, 16'hA5C3, 4);
    rd(1, 5, 16'hA5C3, 1, "t2_rd15");
    rd(0, 5, 16'h0000, 0, "t2_rd05");

    rd_ch = 1; rd_idx = 5;
    strobe(1, 5, 16'h0F0F, 1);
    chk("t2_rbw_old", rd_data, 16'hA5C3);
    @(negedge Sclk);
    chk("t2_rbw_new", rd_data, 16'h0F0F);

    strobe(0, 16, 16'h5555, 1);
    chk("t3_drop_set", wr_drop, 1);
    repeat (3) @(negedge Sclk);
    chk("t3_drop_sticky", wr_drop, 1);
    rd(0, 0, 16'h0000, 0, "t3_rd00");
    @(negedge Sclk);
    init = 1'b1;
    @(negedge Sclk);
    init = 1'b0;
    chk("t3_drop_clr", wr_drop, 0);
    count_busy("t3_busy_cycles");

    strobe(1, 15, 16'h1111, 1);
    chk("t4_frame_hi", frame_done, 1);
    @(negedge Sclk);
    chk("t4_frame_lo", frame_done, 0);
    strobe(0, 15, 16'h2222, 1);
    chk("t4_no_frame", frame_done, 0);
    @(negedge Sclk);
    chk("t4_no_frame2", frame_done, 0);

    strobe(0, 3, 16'h1234, 1);
    rd(0, 3, 16'h1234, 1, "t5_pre03");
    @(negedge Sclk);
    init = 1'b1; rj_status = 1'b1; wr_ch = 0; wr_row = 4; Input = 16'hBEEF;
    @(negedge Sclk);
    init = 1'b0; rj_status = 1'b0;
    chk("t5_drop", wr_drop, 1);
    count_busy("t5_busy_cycles");
    chk("t5_drop_after", wr_drop, 1);
    rd(0, 3, 16'h0000, 0, "t5_rd03");
    rd(0, 4, 16'h0000, 0, "t5_rd04");

    @(negedge Sclk);
    rj_e = 1'b1; wr_ch_e = 0; wr_row_e = 2; in_e = 12'h800; rd_ch_e = 0; rd_idx_e = 2;
    @(negedge Sclk);
    rj_e = 1'b0;
    chk("t6_same_cycle", rd_data_e, 16'h0000);
    @(negedge Sclk);
    chk("t6_ext", rd_data_e, ExpExt);
    chk("t6_ext_valid", rd_valid_e, 1);
    rj_e = 1'b1; in_e = 12'h7FF;
    @(negedge Sclk);
    rj_e = 1'b0;
    chk("t6_rbw_old", rd_data_e, ExpExt);
    @(negedge Sclk);
    chk("t6_pos", rd_data_e, 16'h07FF);

    repeat (3) @(negedge Sclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
